// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles and validates command frames behind a byte UART receiver.
// Define UART_CMD_CHKSUM_EN to add the trailing XOR checksum byte (5-byte frames).
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  CMD_WRITE      = 8'h57
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  localparam logic [1:0]  ErrCmd      = 2'b01;
  localparam logic [1:0]  ErrTimeout  = 2'b11;
  localparam logic [23:0] TimeoutLast = 24'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_CHKSUM_EN
  localparam logic [1:0]  ErrChk      = 2'b10;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StChk, StExec} state_e;
`else
  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StExec} state_e;
`endif

  state_e      state_q;
  logic [7:0]  addr_q;
  logic [23:0] idle_cnt_q;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]  cmd_q;
  logic [7:0]  data_q;
`endif

  logic accept;
  logic in_frame;
  logic timeout_hit;

  always_comb begin
    rx_data_ready = (state_q != StExec);
    busy          = (state_q != StIdle);
    accept        = rx_data_valid & rx_data_ready;
    // Bytes of a frame after sync: the only states where the idle counter runs.
    in_frame      = busy & (state_q != StExec);
    // An accepted byte on the same edge always beats the timeout.
    timeout_hit   = in_frame & ~accept & (idle_cnt_q == TimeoutLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      idle_cnt_q <= '0;
`ifdef UART_CMD_CHKSUM_EN
      cmd_q      <= '0;
      data_q     <= '0;
`endif
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      frame_cnt  <= '0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;

      if (accept || !in_frame) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + 24'd1;
      end

      if (timeout_hit) begin
        state_q    <= StIdle;
        frame_err  <= 1'b1;
        err_code   <= ErrTimeout;
        idle_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
              state_q <= StCmd;
            end
          end
          StCmd: begin
            if (accept) begin
              if (rx_data == CMD_WRITE) begin
`ifdef UART_CMD_CHKSUM_EN
                cmd_q   <= rx_data;
`endif
                state_q <= StAddr;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ErrCmd;
                state_q   <= StIdle;
              end
            end
          end
          StAddr: begin
            if (accept) begin
              addr_q  <= rx_data;
              state_q <= StData;
            end
          end
          StData: begin
            if (accept) begin
`ifdef UART_CMD_CHKSUM_EN
              data_q  <= rx_data;
              state_q <= StChk;
`else
              wr_en     <= 1'b1;
              wr_addr   <= addr_q;
              wr_data   <= rx_data;
              frame_cnt <= frame_cnt + 8'd1;
              state_q   <= StExec;
`endif
            end
          end
`ifdef UART_CMD_CHKSUM_EN
          StChk: begin
            if (accept) begin
              if (rx_data == (cmd_q ^ addr_q ^ data_q)) begin
                wr_en     <= 1'b1;
                wr_addr   <= addr_q;
                wr_data   <= data_q;
                frame_cnt <= frame_cnt + 8'd1;
                state_q   <= StExec;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ErrChk;
                state_q   <= StIdle;
              end
            end
          end
`endif
          // Outputs were registered on entry, so EXEC is just the strobe cycle.
          StExec: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed vector table, timeout/reset/wrap
// sequences, and a randomized byte stream checked against a frame-level parser model.
module tb_uart_cmd_ctrl;

  localparam int unsigned TO   = 100;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  CMD  = 8'h57;
`ifdef UART_CMD_CHKSUM_EN
  localparam int FrameLen = 5;
`else
  localparam int FrameLen = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_cnt;
  logic       busy;

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE     (SYNC),
    .CMD_WRITE     (CMD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // code 0 = write event, otherwise the err_code seen with the frame_err pulse
  typedef struct packed {
    logic [1:0] code;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    int          errs;
    logic [1:0]  code;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   wr_cnt, err_cnt, rdy_bad;
  ev_t  dut_q[$];
  ev_t  exp_q[$];
  logic [7:0] stim_q[$];

  vec_t        vt[6];
  logic [63:0] bb;
  logic [7:0]  ra, rd, last_a;
  int unsigned r;
  int          e_cnt, early;
  logic [1:0]  e_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_cnt++;
        dut_q.push_back('{code: 2'b00, a: wr_addr, d: wr_data});
      end
      if (frame_err) begin
        err_cnt++;
        dut_q.push_back('{code: err_code, a: 8'h00, d: 8'h00});
      end
      if (wr_en && rx_data_ready) rdy_bad++;
    end
  end

  task automatic clr();
    wr_cnt  = 0;
    err_cnt = 0;
    rdy_bad = 0;
    dut_q.delete();
  endtask

  task automatic do_reset();
    rx_data_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer a byte, hold valid until the accepting edge, then drop it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    @(negedge clk);
    rx_data = b;
    rx_data_valid = 1'b1;
    w = 0;
    while (!rx_data_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!rx_data_ready) begin
      n_err++;
      $display("FAIL ready_wait: got ready=0 expected 1 within 10 cycles");
    end
    @(posedge clk);
    #1 rx_data_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
    send_byte(SYNC, 0);
    send_byte(CMD, 0);
    send_byte(a, 0);
    send_byte(d, 0);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(CMD ^ a ^ d, 0);
`endif
  endtask

  // Frame-level parse of a contiguous (timeout-free) byte stream.
  function automatic void model_run();
    int i = 0;
    int n = stim_q.size();
    logic [7:0] a, d;
    exp_q.delete();
    while (i < n) begin
      if (stim_q[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        exp_q.push_back('{code: 2'b11, a: 8'h00, d: 8'h00});
        break;
      end
      if (stim_q[i+1] != CMD) begin
        exp_q.push_back('{code: 2'b01, a: 8'h00, d: 8'h00});
        i += 2;
        continue;
      end
      if (i + FrameLen > n) begin
        exp_q.push_back('{code: 2'b11, a: 8'h00, d: 8'h00});
        break;
      end
      a = stim_q[i+2];
      d = stim_q[i+3];
`ifdef UART_CMD_CHKSUM_EN
      if (stim_q[i+4] != (CMD ^ a ^ d)) exp_q.push_back('{code: 2'b10, a: 8'h00, d: 8'h00});
      else exp_q.push_back('{code: 2'b00, a: a, d: d});
`else
      exp_q.push_back('{code: 2'b00, a: a, d: d});
`endif
      i += FrameLen;
    end
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{64'hA557103C7B000000, 5, 1, 8'h10, 8'h3C, 0, 2'b00};
`ifdef UART_CMD_CHKSUM_EN
    vt[1] = '{64'hA557103C00000000, 5, 0, 8'h10, 8'h3C, 1, 2'b10};
`else
    vt[1] = '{64'hA557103C00000000, 5, 1, 8'h10, 8'h3C, 0, 2'b00};
`endif
    vt[2] = '{64'h33A512A557010254, 8, 1, 8'h01, 8'h02, 1, 2'b01};
    vt[3] = '{64'hA55720FF88000000, 5, 1, 8'h20, 8'hFF, 0, 2'b01};
    vt[4] = '{64'hA5A5A55740415600, 7, 1, 8'h40, 8'h41, 1, 2'b01};
    vt[5] = '{64'hA557FF00A8000000, 5, 1, 8'hFF, 8'h00, 0, 2'b01};

    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    rst_n = 1'b0;
    clr();
    #3;
    check("rst_ready", rx_data_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    e_cnt = 0;
    for (int v = 0; v < 6; v++) begin
      clr();
      bb = vt[v].bytes;
      for (int k = 0; k < vt[v].n; k++) send_byte(bb[63-8*k -: 8], 0);
      repeat (3) @(negedge clk);
      e_cnt += vt[v].wr;
      check($sformatf("row%0d_wr_pulses", v), wr_cnt, vt[v].wr);
      check($sformatf("row%0d_err_pulses", v), err_cnt, vt[v].errs);
      check($sformatf("row%0d_wr_addr", v), wr_addr, vt[v].addr);
      check($sformatf("row%0d_wr_data", v), wr_data, vt[v].data);
      check($sformatf("row%0d_err_code", v), err_code, vt[v].code);
      check($sformatf("row%0d_frame_cnt", v), frame_cnt, e_cnt[7:0]);
      check($sformatf("row%0d_busy", v), busy, 0);
      check($sformatf("row%0d_ready_in_exec", v), rdy_bad, 0);
    end

    // Timeout fires exactly TO cycles after the last accepted byte
    clr();
    send_byte(SYNC, 0);
    send_byte(CMD, 0);
    early = 0;
    for (int k = 1; k < TO; k++) begin
      @(posedge clk);
      #1;
      if (frame_err) early++;
    end
    check("to_busy_before", busy, 1);
    @(posedge clk);
    #1;
    check("to_no_early_err", early, 0);
    check("to_frame_err", frame_err, 1);
    check("to_err_code", err_code, 2'b11);
    check("to_busy_after", busy, 0);
    @(posedge clk);
    #1;
    check("to_pulse_len", frame_err, 0);

    // A byte landing on the timeout edge wins
    clr();
    send_byte(SYNC, 0);
    send_byte(CMD, 0);
    repeat (TO - 1) @(posedge clk);
    send_byte(8'h10, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h7B, 0);
    repeat (3) @(negedge clk);
    check("tosup_err_pulses", err_cnt, 0);
    check("tosup_wr_pulses", wr_cnt, 1);
    check("tosup_wr_addr", wr_addr, 8'h10);
    check("tosup_wr_data", wr_data, 8'h3C);

    // Reset mid-frame: immediate clear, next byte treated as an idle byte
    send_byte(SYNC, 0);
    send_byte(CMD, 0);
    send_byte(8'h10, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_ready", rx_data_ready, 1);
    check("mrst_wr_addr", wr_addr, 0);
    check("mrst_wr_data", wr_data, 0);
    check("mrst_err_code", err_code, 0);
    check("mrst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    send_byte(8'h3C, 0);
    repeat (3) @(negedge clk);
    check("mrst_3c_busy", busy, 0);
    check("mrst_3c_events", wr_cnt + err_cnt, 0);
    send_frame(8'h55, 8'h66);
    repeat (3) @(negedge clk);
    check("mrst_recover_addr", wr_addr, 8'h55);
    check("mrst_recover_data", wr_data, 8'h66);

    // Randomized stream against the frame-level model
    do_reset();
    clr();
    stim_q.delete();
    for (int f = 0; f < 80; f++) begin
      r  = $urandom_range(0, 5);
      ra = 8'($urandom);
      rd = 8'($urandom);
      case (r)
        0: stim_q.push_back(8'($urandom));
        1: begin
          stim_q.push_back(SYNC);
          stim_q.push_back(8'($urandom));
        end
        2: begin
          stim_q.push_back(SYNC);
          stim_q.push_back(CMD);
          stim_q.push_back(ra);
          stim_q.push_back(rd);
          stim_q.push_back(8'($urandom));
        end
        default: begin
          stim_q.push_back(SYNC);
          stim_q.push_back(CMD);
          stim_q.push_back(ra);
          stim_q.push_back(rd);
          stim_q.push_back(CMD ^ ra ^ rd);
        end
      endcase
    end
    foreach (stim_q[k]) send_byte(stim_q[k], int'($urandom_range(0, 3)));
    repeat (TO + 50) @(negedge clk);
    model_run();
    e_cnt  = 0;
    e_code = 2'b00;
    foreach (exp_q[k]) begin
      if (exp_q[k].code == 2'b00) e_cnt++;
      else e_code = exp_q[k].code;
    end
    check("rand_event_count", dut_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < dut_q.size(); k++) begin
      check($sformatf("rand_event%0d", k), dut_q[k], exp_q[k]);
    end
    check("rand_frame_cnt", frame_cnt, e_cnt[7:0]);
    check("rand_err_code", err_code, e_code);
    check("rand_ready_in_exec", rdy_bad, 0);

    // frame_cnt wrap
    do_reset();
    clr();
    last_a = 8'h00;
    for (int f = 0; f < 256; f++) begin
      last_a = 8'($urandom);
      send_frame(last_a, 8'($urandom));
      if (f == 254) check("wrap_cnt_255", frame_cnt, 8'hFF);
    end
    repeat (2) @(negedge clk);
    check("wrap_cnt_0", frame_cnt, 8'h00);
    check("wrap_wr_pulses", wr_cnt, 256);
    check("wrap_wr_addr", wr_addr, last_a);
    check("wrap_err_pulses", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame-level controller that sits directly behind the byte-level UART receiver. It sequences the receiver through its valid/ready handshake, assembles fixed-format command frames, and validates them: sync byte, command, address, data, and optional XOR checksum. Each accepted frame becomes a single-cycle register-write strobe toward the on-chip register file. Malformed, unknown or stalled frames are discarded and reported through an error pulse and a sticky error code.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1_000_000: max clk cycles allowed between bytes inside a frame (10 ms at 100 MHz); legal range 2 to 2^24-1.
- SYNC_BYTE, default 8'hA5: frame start marker.
- CMD_WRITE, default 8'h57: the only legal command code.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_data_valid  in  1  receiver holds high until byte consumed.
- rx_data_ready  out  1  combinational; consume byte.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  8  write address, held until next write.
- wr_data  out  8  write data, held until next write.
- frame_err  out  1  one-cycle error pulse.
- err_code  out  2  last error: 01 bad cmd, 10 checksum, 11 timeout; 00 none since reset.
- frame_cnt  out  8  good-frame count, wraps 255 to 0.
- busy  out  1  high when state is not IDLE.

## Operation
- A byte is accepted on any rising edge where rx_data_valid and rx_data_ready are both high.
- rx_data_ready = 1 in IDLE, CMD, ADDR, DATA and CHK; 0 in EXEC. Purely a function of state; it does not depend on rx_data_valid.
- States and transitions:
  - IDLE: accepted byte == SYNC_BYTE goes to CMD. Any other byte is discarded silently, with no error.
  - CMD: byte == CMD_WRITE goes to ADDR and latches cmd. Any other byte, including SYNC_BYTE, pulses frame_err, sets err_code=01 and returns to IDLE.
  - ADDR: latch addr, go to DATA.
  - DATA: latch data. Go to CHK if the checksum feature is compiled in, else to EXEC.
  - CHK: if byte == cmd^addr^data, go to EXEC. Otherwise pulse frame_err, set err_code=10 and return to IDLE.
  - EXEC: one cycle. wr_en=1, wr_addr/wr_data loaded from the latches, frame_cnt+1. Then IDLE.
- Timeout:
  - A 24-bit idle counter clears on every accepted byte and on entry to IDLE, and increments each cycle in CMD, ADDR, DATA and CHK when no byte is accepted.
  - When the counter reaches TIMEOUT_CYCLES-1, the controller pulses frame_err, sets err_code=11 and returns to IDLE.
  - If a byte is accepted on the same edge the timeout would fire, the byte wins and no timeout occurs.
- The counter never runs in IDLE; the controller waits indefinitely for sync.
- err_code is sticky: it changes only on a new error or on reset.

## Timing
- Reset (async, immediate): state=IDLE, rx_data_ready=1 (IDLE), wr_en=0, wr_addr=0, wr_data=0, frame_err=0, err_code=00, frame_cnt=0, busy=0, idle counter=0, latches=0.
- Reset asserted mid-frame: the partial frame is lost with no error reported. The first byte accepted after release is evaluated as an IDLE byte.
- Latency: wr_en is high exactly one cycle, starting the cycle after the edge that accepted the final frame byte. wr_addr and wr_data are valid in that same cycle.
- frame_err rises the cycle after the offending edge and lasts one cycle.
- Back-to-back frames: the receiver's valid drops the cycle after acceptance, so EXEC never blocks a pending byte. A byte valid during EXEC is accepted in the following IDLE cycle.
- Minimum spacing between wr_en pulses is frame length × byte time. The block holds no FIFO and has no downstream backpressure; the register file must accept a write every cycle.

## Configuration
- UART_CMD_CHKSUM_EN defined:
  - Frames are 5 bytes (sync, cmd, addr, data, chk).
  - CHK state is present; err_code 10 is reachable.
- UART_CMD_CHKSUM_EN undefined:
  - Frames are 4 bytes.
  - CHK state and comparator are removed; DATA goes directly to EXEC.
  - err_code 10 never occurs.

## Test plan
- Good frame (macro defined): A5 57 10 3C 7B -> one wr_en pulse with wr_addr=10, wr_data=3C; frame_cnt=1; frame_err never asserted.
- Bad checksum: A5 57 10 3C 00 -> no wr_en; frame_err pulse; err_code=10. A following good frame then writes normally.
- Bad command and resync: 33 A5 12 A5 57 01 02 54 -> 33 ignored; 12 gives err_code=01; the next frame writes addr 01 / data 02.
- Timeout: A5 57, then silence for TIMEOUT_CYCLES (set to 100 on the bench) -> frame_err on cycle 100 after the last accept; err_code=11; busy=0. A byte arriving at cycle 99 suppresses the timeout.
- Reset mid-frame: A5 57 10, then pulse rst_n low -> all outputs return to reset values immediately; a subsequent 3C is ignored as a non-sync byte.
- Wrap: 256 good frames -> frame_cnt returns to 0. With the macro undefined, A5 57 20 FF writes addr 20 / data FF after 4 bytes.
